// File: rtl/ts_pkg.sv
// Shared timestamp field widths and the packed {sec, ns} record used by the RTC,
// its register interface and the capture queue.
package ts_pkg;

    localparam int unsigned NS_W  = 38;
    localparam int unsigned SEC_W = 48;
    localparam int unsigned TS_W  = SEC_W + NS_W;

    typedef struct packed {
        logic [SEC_W-1:0] sec;
        logic [NS_W-1:0]  ns;
    } ts_t;

endpackage

// File: rtl/ts_fifo.sv
// Synchronous show-ahead FIFO with a separately tracked occupancy count.
// Storage is cleared on reset so the head reads zero after reset.
module ts_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_wr, do_rd;

    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign rd_data = mem_q[rd_ptr_q];

    // A write into a full queue is only legal when a pop frees the slot in the same cycle.
    assign do_rd = rd_en & ~empty;
    assign do_wr = wr_en & (~full | do_rd);

    always_comb begin
        cnt_d = cnt_q;
        case ({do_wr, do_rd})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (do_wr) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_rd) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/ts_capture.sv
// Event timestamp capture: synchronizes an asynchronous strobe, detects its rising
// edge and queues the RTC {sec, ns} value sampled on the detecting clock edge.
module ts_capture
    import ts_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned SYNC_STAGES = 2,
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NS_W-1:0]  time_reg_ns,
    input  logic [SEC_W-1:0] time_reg_sec,
    input  logic             evt_in,
    input  logic             evt_en,
    input  logic             ts_rd,
    input  logic             ovf_clr,
    output logic             ts_valid,
    output logic [NS_W-1:0]  ts_ns,
    output logic [SEC_W-1:0] ts_sec,
    output logic [CNT_W-1:0] ts_cnt,
    output logic             ts_ovf
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   dly_q;
    logic                   evt_rise, capture, ovf_set;
    logic                   ovf_q;
    logic                   fifo_full, fifo_empty;
    ts_t                    wr_ts, rd_ts;

    // The delay flop runs regardless of evt_en, so enabling mid-pulse never captures.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], evt_in};
            dly_q  <= sync_q[SYNC_STAGES-1];
        end
    end

    assign evt_rise = sync_q[SYNC_STAGES-1] & ~dly_q;
    assign capture  = evt_rise & evt_en;
    assign ovf_set  = capture & fifo_full & ~ts_rd;

    assign wr_ts.sec = time_reg_sec;
    assign wr_ts.ns  = time_reg_ns;

    ts_fifo #(
        .WIDTH (TS_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (capture),
        .wr_data (wr_ts),
        .rd_en   (ts_rd),
        .rd_data (rd_ts),
        .count   (ts_cnt),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Set has priority over clear so a simultaneous overflow is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (ovf_set) begin
            ovf_q <= 1'b1;
        end else if (ovf_clr) begin
            ovf_q <= 1'b0;
        end
    end

    assign ts_valid = ~fifo_empty;
    assign ts_ns    = rd_ts.ns;
    assign ts_sec   = rd_ts.sec;
    assign ts_ovf   = ovf_q;

endmodule

// File: tb/tb_ts_capture.sv
// Directed bench for ts_capture: per-cycle vector table plus hand sequences for
// latency, full-queue interactions, overflow clear priority and async reset.
module tb_ts_capture;
    import ts_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NS_W-1:0]  time_reg_ns = '0;
    logic [SEC_W-1:0] time_reg_sec = '0;
    logic             evt_in = 1'b0;
    logic             evt_en = 1'b1;
    logic             ts_rd = 1'b0;
    logic             ovf_clr = 1'b0;
    logic             ts_valid;
    logic [NS_W-1:0]  ts_ns;
    logic [SEC_W-1:0] ts_sec;
    logic [2:0]       ts_cnt;
    logic             ts_ovf;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ts_capture #(
        .FIFO_DEPTH  (4),
        .SYNC_STAGES (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .time_reg_ns  (time_reg_ns),
        .time_reg_sec (time_reg_sec),
        .evt_in       (evt_in),
        .evt_en       (evt_en),
        .ts_rd        (ts_rd),
        .ovf_clr      (ovf_clr),
        .ts_valid     (ts_valid),
        .ts_ns        (ts_ns),
        .ts_sec       (ts_sec),
        .ts_cnt       (ts_cnt),
        .ts_ovf       (ts_ovf)
    );

    typedef struct {
        bit evt, en, rd, clr;
        bit chk_head;
        bit v;
        int cnt;
        bit ovf;
        int hs, hn;
    } row_t;

    row_t rows[$];

    task automatic add(input bit e, input bit en, input bit rd, input bit clr, input bit ch,
                       input bit v, input int c, input bit o, input int hs, input int hn);
        row_t r;
        r.evt = e; r.en = en; r.rd = rd; r.clr = clr; r.chk_head = ch;
        r.v = v; r.cnt = c; r.ovf = o; r.hs = hs; r.hn = hn;
        rows.push_back(r);
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; evt_in = 1'b0; ts_rd = 1'b0; ovf_clr = 1'b0; evt_en = 1'b1;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    // Three-edge pulse; the capture happens on the third edge with rd/clr applied there.
    task automatic pulse(input logic [SEC_W-1:0] sec, input logic [NS_W-1:0] ns,
                         input bit rd, input bit clr);
        time_reg_sec = sec; time_reg_ns = ns;
        evt_in = 1'b1;
        tick(); tick();
        evt_in = 1'b0; ts_rd = rd; ovf_clr = clr;
        tick();
        ts_rd = 1'b0; ovf_clr = 1'b0;
    endtask

    initial begin
        // evt en rd clr | chk_head valid cnt ovf head_sec head_ns
        add(1,1,0,0, 0,0,0,0,  0,   0);     // 0
        add(1,1,0,0, 0,0,0,0,  0,   0);
        add(0,1,0,0, 1,1,1,0,102,1002);     // 2: first capture
        add(0,1,0,0, 1,1,1,0,102,1002);
        add(1,1,0,0, 1,1,1,0,102,1002);
        add(1,1,0,0, 1,1,1,0,102,1002);
        add(0,1,0,0, 1,1,2,0,102,1002);     // 6
        add(0,1,0,0, 1,1,2,0,102,1002);
        add(1,1,0,0, 1,1,2,0,102,1002);
        add(1,1,0,0, 1,1,2,0,102,1002);
        add(0,1,0,0, 1,1,3,0,102,1002);     // 10
        add(0,1,0,0, 1,1,3,0,102,1002);
        add(1,1,0,0, 1,1,3,0,102,1002);
        add(1,1,0,0, 1,1,3,0,102,1002);
        add(0,1,0,0, 1,1,4,0,102,1002);     // 14: full
        add(0,1,0,0, 1,1,4,0,102,1002);
        add(1,1,0,0, 1,1,4,0,102,1002);
        add(1,1,0,0, 1,1,4,0,102,1002);
        add(0,1,0,0, 1,1,4,1,102,1002);     // 18: fifth event dropped
        add(0,1,1,0, 1,1,3,1,106,1006);     // pops in order
        add(0,1,1,0, 1,1,2,1,110,1010);
        add(0,1,1,0, 1,1,1,1,114,1014);
        add(0,1,1,0, 0,0,0,1,  0,   0);
        add(0,1,1,0, 0,0,0,1,  0,   0);     // 23: pop on empty ignored
        add(0,1,0,1, 0,0,0,0,  0,   0);     // 24: ovf_clr
        add(1,0,0,0, 0,0,0,0,  0,   0);     // 25: edge while disabled
        add(1,0,0,0, 0,0,0,0,  0,   0);
        add(1,0,0,0, 0,0,0,0,  0,   0);
        add(1,1,0,0, 0,0,0,0,  0,   0);     // 28: enable while high
        add(0,1,0,0, 0,0,0,0,  0,   0);
        add(0,1,0,0, 0,0,0,0,  0,   0);
        add(1,1,0,0, 0,0,0,0,  0,   0);     // 31
        add(1,1,0,0, 0,0,0,0,  0,   0);
        add(0,1,0,0, 1,1,1,0,133,1033);
        add(1,1,0,0, 1,1,1,0,133,1033);
        add(1,1,0,0, 1,1,1,0,133,1033);
        add(0,1,0,0, 1,1,2,0,133,1033);     // 36
        add(1,1,0,0, 1,1,2,0,133,1033);
        add(1,1,0,0, 1,1,2,0,133,1033);
        add(0,1,1,0, 1,1,2,0,136,1036);     // 39: capture + pop
        add(0,1,1,0, 1,1,1,0,139,1039);
        add(1,1,1,0, 0,0,0,0,  0,   0);     // 41
        add(1,1,0,0, 0,0,0,0,  0,   0);
        add(0,1,1,0, 1,1,1,0,143,1043);     // 43: capture + pop on empty
        add(0,1,1,0, 0,0,0,0,  0,   0);

        // Reset state
        rst_n = 1'b0;
        #1;
        chk("async reset valid", 64'(ts_valid), 64'd0);
        tick();
        chk("reset cnt", 64'(ts_cnt), 64'd0);
        chk("reset ovf", 64'(ts_ovf), 64'd0);
        chk("reset ns", 64'(ts_ns), 64'd0);
        chk("reset sec", 64'(ts_sec), 64'd0);
        do_reset();

        foreach (rows[i]) begin
            evt_in = rows[i].evt; evt_en = rows[i].en;
            ts_rd = rows[i].rd; ovf_clr = rows[i].clr;
            time_reg_sec = SEC_W'(100 + i);
            time_reg_ns  = NS_W'(1000 + i);
            tick();
            chk($sformatf("row%0d valid", i), 64'(ts_valid), 64'(rows[i].v));
            chk($sformatf("row%0d cnt", i), 64'(ts_cnt), 64'(rows[i].cnt));
            chk($sformatf("row%0d ovf", i), 64'(ts_ovf), 64'(rows[i].ovf));
            if (rows[i].chk_head) begin
                chk($sformatf("row%0d sec", i), 64'(ts_sec), 64'(rows[i].hs));
                chk($sformatf("row%0d ns", i), 64'(ts_ns), 64'(rows[i].hn));
            end
        end
        ts_rd = 1'b0; ovf_clr = 1'b0; evt_in = 1'b0; evt_en = 1'b1;

        // Latency: rise before edge 10 -> entry at edge 12
        do_reset();
        time_reg_sec = 48'd5; time_reg_ns = 38'h100;
        repeat (9) tick();
        evt_in = 1'b1;
        tick();
        chk("lat edge10 cnt", 64'(ts_cnt), 64'd0);
        tick();
        chk("lat edge11 valid", 64'(ts_valid), 64'd0);
        tick();
        chk("lat edge12 valid", 64'(ts_valid), 64'd1);
        chk("lat edge12 sec", 64'(ts_sec), 64'd5);
        chk("lat edge12 ns", 64'(ts_ns), 64'h100);
        evt_in = 1'b0;

        // Full queue, capture and pop together
        do_reset();
        for (int k = 1; k <= 4; k++) pulse(SEC_W'(k), NS_W'(k * 16), 1'b0, 1'b0);
        chk("full cnt", 64'(ts_cnt), 64'd4);
        pulse(48'd5, 38'h50, 1'b1, 1'b0);
        chk("full cap+pop cnt", 64'(ts_cnt), 64'd4);
        chk("full cap+pop ovf", 64'(ts_ovf), 64'd0);
        chk("full cap+pop head", 64'(ts_sec), 64'd2);
        ts_rd = 1'b1;
        repeat (3) tick();
        ts_rd = 1'b0;
        chk("tail sec", 64'(ts_sec), 64'd5);
        chk("tail ns", 64'(ts_ns), 64'h50);
        chk("tail cnt", 64'(ts_cnt), 64'd1);

        // Overflow set beats clear
        do_reset();
        for (int k = 1; k <= 4; k++) pulse(SEC_W'(k), NS_W'(k), 1'b0, 1'b0);
        pulse(48'd9, 38'd9, 1'b0, 1'b0);
        chk("ovf set", 64'(ts_ovf), 64'd1);
        chk("ovf head kept", 64'(ts_sec), 64'd1);
        pulse(48'd10, 38'd10, 1'b0, 1'b1);
        chk("ovf set wins", 64'(ts_ovf), 64'd1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf clr alone", 64'(ts_ovf), 64'd0);
        chk("ovf cnt kept", 64'(ts_cnt), 64'd4);

        // Async reset mid-operation, then evt held high across release
        do_reset();
        for (int k = 0; k < 3; k++) pulse(SEC_W'('h21 + k), NS_W'('h300 + k), 1'b0, 1'b0);
        chk("pre-rst cnt", 64'(ts_cnt), 64'd3);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async rst cnt", 64'(ts_cnt), 64'd0);
        chk("async rst valid", 64'(ts_valid), 64'd0);
        chk("async rst ns", 64'(ts_ns), 64'd0);
        chk("async rst sec", 64'(ts_sec), 64'd0);
        evt_in = 1'b1; evt_en = 1'b1;
        time_reg_sec = 48'd77; time_reg_ns = 38'h77;
        tick(); tick();
        #2;
        rst_n = 1'b1;
        tick(); tick(); tick();
        chk("rel capture cnt", 64'(ts_cnt), 64'd1);
        chk("rel capture sec", 64'(ts_sec), 64'd77);
        repeat (3) tick();
        chk("rel single capture", 64'(ts_cnt), 64'd1);
        evt_in = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
